// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the line-fill responder and the cache that talks to it:
// FSM state encoding, default line/latency constants and counter width.
package mem_line_responder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_BUSY  = 2'd3
    } state_t;

    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_RD_LATENCY     = 4;
    localparam int DEF_WR_LATENCY     = 2;

    // Wide enough for the largest latency (15) and the largest beat index (15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Every word starts out holding its own byte address (index * 4); a word
// returns the stored value only once it has been written.
module mem_word_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Power-up contents are described by these flags rather than by loading
    // the array, so the array itself stays a plain RAM. No reset touches them.
    logic [DEPTH_WORDS-1:0] written = '0;

    logic [DATA_W-1:0] init_val;

    // Synchronous write; marks the word as holding real data from now on.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr]     <= wdata;
            written[waddr] <= 1'b1;
        end
    end

    // Combinational read: unwritten words read back as their byte address.
    always_comb begin
        init_val = DATA_W'(raddr) << 2;
        rdata    = written[raddr] ? mem[raddr] : init_val;
    end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder for a cache: accepts single-word writes and line
// reads, returning a line as a critical-word-first burst that wraps within
// the line.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is 1 only in IDLE. Once resp_valid is raised it stays up,
// with resp_data/resp_last stable, until resp_ready accepts the beat.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int RD_LATENCY     = DEF_RD_LATENCY,
    parameter int WR_LATENCY     = DEF_WR_LATENCY,
    parameter int DEPTH_WORDS    = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    input  logic              resp_ready,
    output logic [1:0]        dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int OW = $clog2(WORDS_PER_LINE);

    localparam logic [CNT_W-1:0] RD_WAIT_END = CNT_W'(RD_LATENCY - 2);
    localparam logic [CNT_W-1:0] WR_END      = CNT_W'(WR_LATENCY - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(WORDS_PER_LINE - 1);

    state_t            state;
    logic [CNT_W-1:0]  lat_cnt;
    logic [CNT_W-1:0]  beat_cnt;
    logic [AW-1:0]     cap_idx;

    logic [AW-1:0]     req_idx;
    logic [AW-1:0]     base_idx;
    logic [CNT_W-1:0]  step;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic              mem_we;
    logic              unused_addr;

    // Word index is the byte address divided by four; upper bits alias.
    assign req_idx     = req_addr[2 +: AW];
    assign unused_addr = ^{req_addr[1:0], req_addr[ADDR_W-1:AW+2]};

    assign req_ready = (state == IDLE);
    assign dbg_state = state;

    // The write lands in storage on the very edge it is accepted.
    assign mem_we = reset_n && (state == IDLE) && req_valid && req_write;

    mem_word_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (req_idx),
        .wdata (req_wdata),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    // Address of the word to load into resp_data at the next edge: beat 0
    // before the burst starts, otherwise the beat after the one on display.
    // Only the in-line offset bits advance, so the burst wraps inside the line.
    always_comb begin
        base_idx = cap_idx;
        step     = '0;
        case (state)
            IDLE:     base_idx = req_idx;
            RD_BURST: step     = beat_cnt + 1'b1;
            default:  ;
        endcase
        rd_idx          = base_idx;
        rd_idx[OW-1:0]  = base_idx[OW-1:0] + step[OW-1:0];
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            beat_cnt   <= '0;
            cap_idx    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_idx <= req_idx;
                        if (req_write) begin
                            state <= WR_BUSY;
                        end else if (RD_LATENCY == 1) begin
                            state      <= RD_BURST;
                            resp_valid <= 1'b1;
                            resp_data  <= rd_word;
                            resp_last  <= 1'b0;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == RD_WAIT_END) begin
                        state      <= RD_BURST;
                        lat_cnt    <= '0;
                        resp_valid <= 1'b1;
                        resp_data  <= rd_word;
                        resp_last  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RD_BURST: begin
                    if (resp_ready) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state      <= IDLE;
                            beat_cnt   <= '0;
                            resp_valid <= 1'b0;
                            resp_data  <= '0;
                            resp_last  <= 1'b0;
                        end else begin
                            beat_cnt  <= beat_cnt + 1'b1;
                            resp_data <= rd_word;
                            resp_last <= (beat_cnt == LAST_BEAT - 1'b1);
                        end
                    end
                end
                WR_BUSY: begin
                    if (lat_cnt == WR_END) begin
                        state   <= IDLE;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
